// File: rtl/am2940_seq.sv
// am2940_seq: drives an Am2940-style address generator through a setup sequence and per-word stepping.
// Latency: 4 cycles from accepted start to first mem_req; each word takes XFER (>=1), STEP, CHECK.
// Backpressure: XFER waits indefinitely for mem_ack; start is ignored while busy; abort returns to IDLE.
module am2940_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_len,
  input  logic [2:0] cfg_ctrl,
  output logic       busy,
  output logic       done_irq,
  output logic       err,
  output logic [7:0] xfer_cnt,
  output logic       mem_req,
  input  logic       mem_ack,
  output logic [2:0] am_instr,
  output logic [7:0] am_data,
  output logic       am_cina_n,
  output logic       am_cinw_n,
  input  logic       am_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRCR  = 3'd1,
    S_LDAD  = 3'd2,
    S_LDWC  = 3'd3,
    S_XFER  = 3'd4,
    S_STEP  = 3'd5,
    S_CHECK = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  // Address-generator instruction codes
  localparam logic [2:0] I_WRCR = 3'd0;
  localparam logic [2:0] I_RDCR = 3'd1;  // harmless NOP while idle or waiting
  localparam logic [2:0] I_LDAD = 3'd5;
  localparam logic [2:0] I_LDWC = 3'd6;
  localparam logic [2:0] I_ENCT = 3'd7;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] len_q, len_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // State and captured-configuration registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= 8'd0;
      len_q   <= 8'd0;
      ctrl_q  <= 3'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state, configuration capture, word counting and error-pulse generation
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    // The memory cycle already completed on entry to STEP, so it counts even if aborted here
    if (state_q == S_STEP) begin
      cnt_d = cnt_q + 8'd1;
    end

    if (state_q == S_IDLE) begin
      if (start) begin
        if (cfg_len == 8'd0) begin
          err_d = 1'b1;
        end else begin
          addr_d  = cfg_addr;
          len_d   = cfg_len;
          ctrl_d  = cfg_ctrl;
          cnt_d   = 8'd0;
          state_d = S_WRCR;
        end
      end
    end else if (abort) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        S_WRCR:  state_d = S_LDAD;
        S_LDAD:  state_d = S_LDWC;
        S_LDWC:  state_d = S_XFER;
        S_XFER:  state_d = mem_ack ? S_STEP : S_XFER;
        S_STEP:  state_d = S_CHECK;
        S_CHECK: state_d = am_done ? S_FIN : S_XFER;
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore decode of the address-generator and bus outputs
  always_comb begin
    am_instr  = I_RDCR;
    am_data   = 8'd0;
    am_cina_n = 1'b1;
    am_cinw_n = 1'b1;
    mem_req   = 1'b0;
    case (state_q)
      S_WRCR: begin
        am_instr = I_WRCR;
        am_data  = {5'd0, ctrl_q};
      end
      S_LDAD: begin
        am_instr = I_LDAD;
        am_data  = addr_q;
      end
      S_LDWC: begin
        am_instr = I_LDWC;
        am_data  = len_q;
      end
      S_XFER: begin
        mem_req = 1'b1;
      end
      S_STEP: begin
        am_instr  = I_ENCT;
        am_cina_n = 1'b0;
        am_cinw_n = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done_irq = (state_q == S_FIN);
  assign err      = err_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_am2940_seq.sv
// tb_am2940_seq: vector table, directed corner sequences and randomized traffic against a transaction model.
// Latency: checks every cycle on the falling edge after the model advances on the rising edge.
// Backpressure: mem_ack and am_done are driven by the bench, either randomly or from the model's word count.
module tb_am2940_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_len;
  logic [2:0] cfg_ctrl;
  logic       busy;
  logic       done_irq;
  logic       err;
  logic [7:0] xfer_cnt;
  logic       mem_req;
  logic       mem_ack;
  logic [2:0] am_instr;
  logic [7:0] am_data;
  logic       am_cina_n;
  logic       am_cinw_n;
  logic       am_done;

  am2940_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_addr  (cfg_addr),
    .cfg_len   (cfg_len),
    .cfg_ctrl  (cfg_ctrl),
    .busy      (busy),
    .done_irq  (done_irq),
    .err       (err),
    .xfer_cnt  (xfer_cnt),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .am_instr  (am_instr),
    .am_data   (am_data),
    .am_cina_n (am_cina_n),
    .am_cinw_n (am_cinw_n),
    .am_done   (am_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done_irq;
    logic       err;
    logic       mem_req;
    logic       cina_n;
    logic       cinw_n;
    logic [2:0] instr;
    logic [7:0] data;
    logic [7:0] cnt;
  } outs_t;

  typedef struct packed {
    logic       start;
    logic [7:0] len;
    logic       ack;
    logic       done;
    outs_t      exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int err_seen = 0;

  // Transaction model: a transfer is a queue of setup words, then a loop of wait/step/check, then a finish cycle
  bit          m_act;
  logic [10:0] m_setup[$];
  int          m_loop;   // 0 waiting for ack, 1 stepping, 2 checking, 3 finishing
  logic [7:0]  m_cnt;
  logic [7:0]  m_len;
  bit          m_err;

  function automatic outs_t o(logic b, logic d, logic e, logic r, logic ca, logic cw,
                              logic [2:0] i, logic [7:0] dt, logic [7:0] c);
    outs_t x;
    x.busy = b; x.done_irq = d; x.err = e; x.mem_req = r;
    x.cina_n = ca; x.cinw_n = cw; x.instr = i; x.data = dt; x.cnt = c;
    return x;
  endfunction

  function automatic outs_t model_out();
    outs_t x;
    x = o(1'b0, 1'b0, m_err, 1'b0, 1'b1, 1'b1, 3'd1, 8'd0, m_cnt);
    if (m_act) begin
      x.busy = 1'b1;
      if (m_setup.size() != 0) begin
        x.instr = m_setup[0][10:8];
        x.data  = m_setup[0][7:0];
      end else begin
        case (m_loop)
          0: x.mem_req = 1'b1;
          1: begin x.instr = 3'd7; x.cina_n = 1'b0; x.cinw_n = 1'b0; end
          3: x.done_irq = 1'b1;
          default: ;
        endcase
      end
    end
    return x;
  endfunction

  function automatic void model_step();
    if (!reset) begin
      m_act = 1'b0; m_setup.delete(); m_loop = 0; m_cnt = 8'd0; m_err = 1'b0;
      return;
    end
    m_err = 1'b0;
    if (!m_act) begin
      if (start) begin
        if (cfg_len == 8'd0) m_err = 1'b1;
        else begin
          m_act = 1'b1; m_len = cfg_len; m_cnt = 8'd0; m_loop = 0;
          m_setup.delete();
          m_setup.push_back({3'd0, 5'd0, cfg_ctrl});
          m_setup.push_back({3'd5, cfg_addr});
          m_setup.push_back({3'd6, cfg_len});
        end
      end
    end else begin
      if (m_setup.size() == 0 && m_loop == 1) m_cnt = m_cnt + 8'd1;
      if (abort) begin
        m_act = 1'b0; m_err = 1'b1; m_setup.delete();
      end else if (m_setup.size() != 0) begin
        void'(m_setup.pop_front());
      end else begin
        case (m_loop)
          0: if (mem_ack) m_loop = 1;
          1: m_loop = 2;
          2: m_loop = am_done ? 3 : 0;
          default: m_act = 1'b0;
        endcase
      end
    end
  endfunction

  function automatic outs_t cur_outs();
    outs_t x;
    x = {busy, done_irq, err, mem_req, am_cina_n, am_cinw_n, am_instr, am_data, xfer_cnt};
    return x;
  endfunction

  task automatic check_model(string name);
    outs_t got, exp;
    got = cur_outs();
    exp = model_out();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
    if (done_irq === 1'b1) done_seen++;
    if (err === 1'b1) err_seen++;
  endtask

  task automatic expect_eq(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(string name);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(name);
  endtask

  task automatic do_start(logic [7:0] a, logic [7:0] l, logic [2:0] c);
    start = 1'b1; cfg_addr = a; cfg_len = l; cfg_ctrl = c;
    abort = 1'b0; mem_ack = 1'b0; am_done = 1'b0;
    cyc("start");
    start = 1'b0;
  endtask

  task automatic run_to_idle(string name, int budget);
    int n;
    n = 0;
    while (m_act && n < budget) begin
      start = 1'b0; abort = 1'b0; mem_ack = 1'b1;
      am_done = (m_cnt >= m_len);
      cyc(name);
      n++;
    end
    if (m_act) begin
      checks++; errors++;
      $display("FAIL %s: still busy after %0d cycles", name, budget);
    end
  endtask

  vec_t vecs[19];
  localparam logic [7:0] A = 8'h40;

  initial begin
    outs_t rst_o, got;
    int d0, e0, n;

    // Basic transfer addr=0x40 len=3, ack one cycle after each request, then a rejected zero-length start
    vecs[0]  = '{1'b1, 8'd3, 1'b0, 1'b0, o(1,0,0,0,1,1,3'd0,8'h00,8'd0)};
    vecs[1]  = '{1'b0, 8'd3, 1'b0, 1'b0, o(1,0,0,0,1,1,3'd5,A,    8'd0)};
    vecs[2]  = '{1'b0, 8'd3, 1'b0, 1'b0, o(1,0,0,0,1,1,3'd6,8'h03,8'd0)};
    vecs[3]  = '{1'b0, 8'd3, 1'b0, 1'b0, o(1,0,0,1,1,1,3'd1,8'h00,8'd0)};
    vecs[4]  = '{1'b0, 8'd3, 1'b0, 1'b0, o(1,0,0,1,1,1,3'd1,8'h00,8'd0)};
    vecs[5]  = '{1'b0, 8'd3, 1'b1, 1'b0, o(1,0,0,0,0,0,3'd7,8'h00,8'd0)};
    vecs[6]  = '{1'b0, 8'd3, 1'b0, 1'b0, o(1,0,0,0,1,1,3'd1,8'h00,8'd1)};
    vecs[7]  = '{1'b0, 8'd3, 1'b0, 1'b0, o(1,0,0,1,1,1,3'd1,8'h00,8'd1)};
    vecs[8]  = '{1'b0, 8'd3, 1'b0, 1'b0, o(1,0,0,1,1,1,3'd1,8'h00,8'd1)};
    vecs[9]  = '{1'b0, 8'd3, 1'b1, 1'b0, o(1,0,0,0,0,0,3'd7,8'h00,8'd1)};
    vecs[10] = '{1'b0, 8'd3, 1'b0, 1'b0, o(1,0,0,0,1,1,3'd1,8'h00,8'd2)};
    vecs[11] = '{1'b0, 8'd3, 1'b0, 1'b0, o(1,0,0,1,1,1,3'd1,8'h00,8'd2)};
    vecs[12] = '{1'b0, 8'd3, 1'b0, 1'b0, o(1,0,0,1,1,1,3'd1,8'h00,8'd2)};
    vecs[13] = '{1'b0, 8'd3, 1'b1, 1'b0, o(1,0,0,0,0,0,3'd7,8'h00,8'd2)};
    vecs[14] = '{1'b0, 8'd3, 1'b0, 1'b0, o(1,0,0,0,1,1,3'd1,8'h00,8'd3)};
    vecs[15] = '{1'b0, 8'd3, 1'b0, 1'b1, o(1,1,0,0,1,1,3'd1,8'h00,8'd3)};
    vecs[16] = '{1'b0, 8'd3, 1'b0, 1'b0, o(0,0,0,0,1,1,3'd1,8'h00,8'd3)};
    vecs[17] = '{1'b1, 8'd0, 1'b0, 1'b0, o(0,0,1,0,1,1,3'd1,8'h00,8'd3)};
    vecs[18] = '{1'b0, 8'd0, 1'b0, 1'b0, o(0,0,0,0,1,1,3'd1,8'h00,8'd3)};

    rst_o = o(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'd0, 8'd0);

    reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_addr = 8'd0; cfg_len = 8'd0;
    cfg_ctrl = 3'd0; mem_ack = 1'b0; am_done = 1'b0;
    m_act = 1'b0; m_loop = 0; m_cnt = 8'd0; m_len = 8'd0; m_err = 1'b0;

    // Reset state
    repeat (2) begin
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
    got = cur_outs();
    checks++;
    if (got !== rst_o) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", got, rst_o);
    end
    reset = 1'b1;

    // Vector table
    for (int i = 0; i < 19; i++) begin
      start = vecs[i].start; cfg_len = vecs[i].len; mem_ack = vecs[i].ack;
      am_done = vecs[i].done; cfg_addr = A; cfg_ctrl = 3'd0; abort = 1'b0;
      @(posedge clk);
      model_step();
      @(negedge clk);
      got = cur_outs();
      checks++;
      if (got !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d: got %h expected %h", i, got, vecs[i].exp);
      end
    end
    start = 1'b0; am_done = 1'b0; mem_ack = 1'b0;

    // Abort in the second XFER of a five-word transfer
    d0 = done_seen;
    do_start(8'h10, 8'd5, 3'b101);
    n = 0;
    while (!(m_act && m_setup.size() == 0 && m_loop == 0 && m_cnt == 8'd1) && n < 20) begin
      mem_ack = 1'b1; am_done = 1'b0;
      cyc("abort_lead");
      n++;
    end
    expect_eq("abort_reach_xfer2", int'(mem_req), 1);
    abort = 1'b1; mem_ack = 1'b0;
    cyc("abort");
    abort = 1'b0;
    expect_eq("abort_busy", int'(busy), 0);
    expect_eq("abort_err", int'(err), 1);
    expect_eq("abort_cnt", int'(xfer_cnt), 1);
    expect_eq("abort_req", int'(mem_req), 0);
    cyc("abort_after");
    expect_eq("abort_err_pulse", int'(err), 0);
    expect_eq("abort_cnt_hold", int'(xfer_cnt), 1);
    expect_eq("abort_no_done", done_seen - d0, 0);

    // mem_ack withheld for 20 cycles
    d0 = done_seen;
    do_start(8'h80, 8'd2, 3'b010);
    n = 0;
    while (!(m_setup.size() == 0 && m_loop == 0) && n < 10) begin
      mem_ack = 1'b0;
      cyc("wait_lead");
      n++;
    end
    for (int k = 0; k < 20; k++) begin
      mem_ack = 1'b0;
      cyc("wait");
      expect_eq("wait_hold", int'({mem_req, am_cina_n, am_cinw_n}), 7);
    end
    run_to_idle("wait_finish", 40);
    expect_eq("wait_cnt", int'(xfer_cnt), 2);
    expect_eq("wait_done_once", done_seen - d0, 1);

    // Reset during STEP, with abort and start also asserted, then a one-word transfer
    do_start(8'h05, 8'd3, 3'b000);
    n = 0;
    while (!(m_setup.size() == 0 && m_loop == 1) && n < 20) begin
      mem_ack = 1'b1; am_done = 1'b0;
      cyc("rst_lead");
      n++;
    end
    expect_eq("rst_in_step", int'(am_cinw_n), 0);
    reset = 1'b0; abort = 1'b1; start = 1'b1; cfg_len = 8'd9;
    d0 = done_seen; e0 = err_seen;
    cyc("rst_step");
    got = cur_outs();
    checks++;
    if (got !== rst_o) begin
      errors++;
      $display("FAIL rst_step_outs: got %h expected %h", got, rst_o);
    end
    reset = 1'b1; abort = 1'b0; start = 1'b0;
    cyc("rst_release");
    expect_eq("rst_no_pulses", (done_seen - d0) + (err_seen - e0), 0);
    do_start(8'h33, 8'd1, 3'b001);
    run_to_idle("rst_len1", 30);
    expect_eq("rst_len1_cnt", int'(xfer_cnt), 1);
    expect_eq("rst_len1_done", done_seen - d0, 1);

    // Start pulsed while busy must not disturb the captured configuration
    d0 = done_seen;
    do_start(8'h22, 8'd4, 3'b110);
    expect_eq("busy_wrcr_data", int'(am_data), 8'h06);
    start = 1'b1; cfg_addr = 8'h99; cfg_len = 8'd7; cfg_ctrl = 3'b001;
    cyc("busy_ldad");
    expect_eq("busy_ldad_data", int'(am_data), 8'h22);
    cyc("busy_ldwc");
    expect_eq("busy_ldwc_data", int'(am_data), 8'h04);
    start = 1'b0;
    run_to_idle("busy_finish", 60);
    expect_eq("busy_cnt", int'(xfer_cnt), 4);
    expect_eq("busy_done_once", done_seen - d0, 1);

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      reset    = ($urandom_range(0, 299) != 0);
      start    = ($urandom_range(0, 5) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      cfg_addr = 8'($urandom);
      cfg_ctrl = 3'($urandom);
      cfg_len  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      mem_ack  = ($urandom_range(0, 1) == 1);
      am_done  = ($urandom_range(0, 2) == 0);
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/am2940_seq.md
AM2940_SEQ -- requirements
Module: am2940_seq

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have port start  input  1  host request to begin a transfer; sampled only in IDLE.
REQ-004 SHALL have port abort  input  1  host request to terminate the current transfer.
REQ-005 SHALL have port cfg_addr  input  8  start address, captured on accepted start.
REQ-006 SHALL have port cfg_len  input  8  word count, captured on accepted start.
REQ-007 SHALL have port cfg_ctrl  input  3  control-register image (bits 1:0 mode, bit 2 address direction), captured on accepted start.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done_irq  output  1  one-cycle pulse on normal completion.
REQ-010 SHALL have port err  output  1  one-cycle pulse on rejected start or abort.
REQ-011 SHALL have port xfer_cnt  output  8  memory cycles completed in the current or last transfer.
REQ-012 SHALL have port mem_req  output  1  memory-cycle request toward the bus.
REQ-013 SHALL have port mem_ack  input  1  bus acknowledge; completes one memory cycle.
REQ-014 SHALL have port am_instr  output  3  instruction to the address generator.
REQ-015 SHALL have port am_data  output  8  data bus toward the address generator datain.
REQ-016 SHALL have port am_cina_n  output  1  address-counter carry-in; active low.
REQ-017 SHALL have port am_cinw_n  output  1  word-counter carry-in; active low.
REQ-018 SHALL have port am_done  input  1  done flag from the address generator.

Function
REQ-019 SHALL use the following instruction codes: 0 write control register, 1 read control register (NOP), 5 load address, 6 load word count, 7 enable counters.
REQ-020 SHALL implement the states IDLE, WRCR, LDAD, LDWC, XFER, STEP, CHECK and FIN.
REQ-021 SHALL, in IDLE, drive am_instr=1, am_data=0, am_cina_n=1, am_cinw_n=1 and mem_req=0.
REQ-022 SHALL, in IDLE with start=1 and cfg_len!=0: capture the cfg inputs, clear xfer_cnt, and enter WRCR next cycle.
REQ-023 SHALL, in IDLE with start=1 and cfg_len=0: stay in IDLE and pulse err for one cycle.
REQ-024 SHALL drive am_instr=0 and am_data={5'b0,ctrl} in WRCR, then go to LDAD.
REQ-025 SHALL drive am_instr=5 and am_data=addr in LDAD, then go to LDWC.
REQ-026 SHALL drive am_instr=6 and am_data=len in LDWC, then go to XFER; the setup latency from start to first mem_req is 4 cycles.
REQ-027 SHALL hold mem_req=1 and am_instr=1 in XFER until mem_ack=1, then go to STEP; there is no timeout.
REQ-028 SHALL, in STEP (exactly one cycle), drive am_instr=7, am_cina_n=0, am_cinw_n=0 and mem_req=0, and increment xfer_cnt with 8-bit wrap.
REQ-029 SHALL, in CHECK, drive am_instr=1, sample am_done, and go to FIN if it is 1, else to XFER.
REQ-030 SHALL, in FIN, pulse done_irq for one cycle and return to IDLE.
REQ-031 SHALL give abort priority over every transition in any state except IDLE: next state IDLE, err pulses, and mem_req drops the following cycle.
REQ-032 SHALL ignore abort in IDLE.
REQ-033 SHALL ignore start outside IDLE, with no queuing.
REQ-034 SHALL hold xfer_cnt after FIN or abort until the next accepted start.
REQ-035 SHALL ignore mem_ack outside XFER.

Reset
REQ-036 SHALL, while reset=0 at a clk edge, enter IDLE and set busy=0, done_irq=0, err=0, xfer_cnt=0, mem_req=0, am_instr=1, am_data=0, am_cina_n=1 and am_cinw_n=1.
REQ-037 SHALL let reset mid-transfer override abort and all other inputs, with no done_irq or err pulse.

Verification
REQ-038 SHALL be covered by: start with addr=0x40, len=3, ctrl=3'b000, and mem_ack one cycle after each mem_req -> instr sequence 0,5,6 on am_data 0x00,0x40,0x03; three STEP cycles; am_done model asserts after the 3rd; done_irq once; xfer_cnt=3.
REQ-039 SHALL be covered by: start with cfg_len=0 -> err pulse, busy stays 0, am_instr stays 1.
REQ-040 SHALL be covered by: abort asserted during the 2nd XFER of a len=5 transfer -> IDLE next cycle, err pulse, xfer_cnt=1, no done_irq.
REQ-041 SHALL be covered by: mem_ack withheld for 20 cycles -> mem_req held high and am_cina_n/am_cinw_n held at 1 throughout.
REQ-042 SHALL be covered by: reset=0 during STEP -> all outputs at reset values next cycle; a subsequent start with len=1 completes with xfer_cnt=1.
REQ-043 SHALL be covered by: start pulsed while busy -> ignored, current transfer unaffected, and captured cfg values unchanged.
